// File: rtl/uart_command_serializer_if.sv
// Signal bundle between command logic / UART TX core and uart_command_serializer.
// The slave modport is the serializer's view; master is the surrounding logic.
interface uart_command_serializer_if;
    // Handshakes: send is a one-cycle request, honoured only while done=1.
    // tx_start is a one-cycle pulse with tx_data valid in that cycle.
    // The UART raises tx_busy to accept the byte and drops it when finished.
    logic [1023:0] input_data;
    logic [7:0]    input_data_size;
    logic          send;
    logic          ble_side;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    dbg_state;

    modport master (
        output input_data, input_data_size, send, ble_side, tx_busy,
        input  tx_data, tx_start, busy, done, error, dbg_state
    );

    modport slave (
        input  input_data, input_data_size, send, ble_side, tx_busy,
        output tx_data, tx_start, busy, done, error, dbg_state
    );
endinterface

// File: rtl/uart_command_serializer.sv
// Streams a latched command buffer byte-by-byte to a UART TX core, then the terminator.
// Define UART_CMD_SER_LEN_PREFIX_EN to send the byte count ahead of the payload.
module uart_command_serializer #(
    parameter int TIMEOUT = 2000
) (
    input logic                     clk,
    input logic                     reset,
    uart_command_serializer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_WAIT_ACCEPT = 3'd2,
        S_WAIT_DONE   = 3'd3,
        S_FINISH      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_PREFIX  = 2'd0,
        PH_PAYLOAD = 2'd1,
        PH_TERM    = 2'd2
    } phase_t;

    state_t          state;
    state_t          state_n;
    phase_t          phase;
    logic [1023:0]   shift_q;
    logic [7:0]      remain_q;
    logic            ble_q;
    logic            term2_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      tx_data_q;
    logic            tx_start_q;
    logic            error_q;

    logic            size_ok;
    logic            tmo_hit;
    logic            last_byte;
    logic            accept;
    logic            reject;
    logic            issue;
    logic            advance;
    logic            abort;
    logic [7:0]      cur_byte;

    assign size_ok   = (bus.input_data_size != 8'd0) && (bus.input_data_size <= 8'd128);
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign last_byte = (phase == PH_TERM) && (ble_q || term2_q);

    // The prefix byte equals remain_q because nothing has been consumed yet.
    always_comb begin
        cur_byte = 8'h00;
        case (phase)
            PH_PREFIX:  cur_byte = remain_q;
            PH_PAYLOAD: cur_byte = shift_q[7:0];
            PH_TERM:    cur_byte = ble_q ? 8'h0D : (term2_q ? 8'hEF : 8'hBE);
            default:    cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.send) begin
                    if (size_ok) begin
                        accept  = 1'b1;
                        state_n = S_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (!bus.tx_busy) begin
                    issue   = 1'b1;
                    state_n = S_WAIT_ACCEPT;
                end
            end
            S_WAIT_ACCEPT: begin
                if (bus.tx_busy) begin
                    state_n = S_WAIT_DONE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    advance = 1'b1;
                    state_n = last_byte ? S_FINISH : S_LOAD;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_PAYLOAD;
            shift_q    <= '0;
            remain_q   <= 8'd0;
            ble_q      <= 1'b0;
            term2_q    <= 1'b0;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            tx_start_q <= issue;
            if (issue) begin
                tx_data_q <= cur_byte;
            end

            if (accept) begin
                error_q <= 1'b0;
            end else if (reject || abort) begin
                error_q <= 1'b1;
            end

            // Counter restarts whenever a wait state is entered or left.
            if ((state == S_WAIT_ACCEPT || state == S_WAIT_DONE) && state_n == state) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end

            if (accept) begin
                shift_q  <= bus.input_data;
                remain_q <= bus.input_data_size;
                ble_q    <= bus.ble_side;
                term2_q  <= 1'b0;
`ifdef UART_CMD_SER_LEN_PREFIX_EN
                phase    <= PH_PREFIX;
`else
                phase    <= PH_PAYLOAD;
`endif
            end else if (advance) begin
                case (phase)
                    PH_PREFIX: begin
                        phase <= PH_PAYLOAD;
                    end
                    PH_PAYLOAD: begin
                        shift_q  <= shift_q >> 8;
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            phase <= PH_TERM;
                        end
                    end
                    PH_TERM: begin
                        term2_q <= 1'b1;
                    end
                    default: begin
                        phase <= PH_PAYLOAD;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.error     = error_q;
    assign bus.busy      = (state == S_LOAD) || (state == S_WAIT_ACCEPT) || (state == S_WAIT_DONE);
    assign bus.done      = (state == S_IDLE) || (state == S_FINISH);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_command_serializer.sv
// Directed bench for uart_command_serializer: vector table plus hand sequences for
// rejects, timeout, mid-transfer reset and the 128-byte boundary.
module tb_uart_command_serializer;

    localparam int TMO = 16;
`ifdef UART_CMD_SER_LEN_PREFIX_EN
    localparam int PFX = 1;
`else
    localparam int PFX = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_command_serializer_if bus();

    uart_command_serializer #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int send_cyc = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_q[$];
    bit uart_en = 1'b1;
    int busy_len = 4;

    typedef struct {
        logic        ble;
        logic [7:0]  size;
        logic [31:0] data;
        int          blen;
        int          n;
        logic [47:0] stream;
    } vec_t;

    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // tx_start monitor and byte scoreboard
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            start_cnt++;
            check("no_back_to_back_start", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx_start: got byte 0x%0h required no start", bus.tx_data);
            end else begin
                check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_start = bus.tx_start;
    end

    // UART TX model: busy one cycle after tx_start, held for busy_len cycles
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1 && uart_en) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic ble, input logic [7:0] size, input logic [1023:0] data);
        @(posedge clk);
        #1;
        bus.ble_side        = ble;
        bus.input_data_size = size;
        bus.input_data      = data;
        bus.send            = 1'b1;
        send_cyc            = cyc;
        @(posedge clk);
        #1;
        bus.send            = 1'b0;
        bus.input_data      = '1;
        bus.input_data_size = 8'd7;
        bus.ble_side        = ~ble;
    endtask

    task automatic wait_done(input int limit, output int fall_cyc, output int done_cyc, output bit busy_gap);
        bit prev_b;
        prev_b   = 1'b0;
        fall_cyc = -1;
        done_cyc = -1;
        busy_gap = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (bus.busy !== 1'b1) busy_gap = 1'b1;
            if (prev_b && bus.tx_busy == 1'b0) fall_cyc = cyc;
            prev_b = bus.tx_busy;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL wait_done: done not seen within %0d cycles", limit);
        end
    endtask

    initial begin
        int base;
        int fall_cyc;
        int done_cyc;
        bit busy_gap;
        logic [47:0] tmp;
        logic [1023:0] big;

        vt[0] = '{ble: 1'b1, size: 8'd3, data: 32'h0054_4141, blen: 10, n: 4, stream: 48'h0000_0D54_4141};
        vt[1] = '{ble: 1'b0, size: 8'd2, data: 32'h0000_2211, blen: 3,  n: 4, stream: 48'h0000_EFBE_2211};
        vt[2] = '{ble: 1'b1, size: 8'd1, data: 32'h1234_567E, blen: 1,  n: 2, stream: 48'h0000_0000_0D7E};
        vt[3] = '{ble: 1'b0, size: 8'd4, data: 32'hDEAD_BEEF, blen: 5,  n: 6, stream: 48'hEFBE_DEAD_BEEF};
        vt[4] = '{ble: 1'b0, size: 8'd1, data: 32'h0000_0000, blen: 15, n: 3, stream: 48'h0000_00EF_BE00};

        reset               = 1'b1;
        bus.send            = 1'b0;
        bus.ble_side        = 1'b0;
        bus.input_data      = '0;
        bus.input_data_size = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd1);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven commands
        for (int v = 0; v < 5; v++) begin
            busy_len = vt[v].blen;
            base = start_cnt;
            if (PFX == 1) exp_q.push_back(vt[v].size);
            for (int b = 0; b < vt[v].n; b++) begin
                tmp = vt[v].stream >> (8 * b);
                exp_q.push_back(tmp[7:0]);
            end
            send_cmd(vt[v].ble, vt[v].size, 1024'(vt[v].data));
            wait_done(2000, fall_cyc, done_cyc, busy_gap);
            check($sformatf("vec%0d_starts", v), start_cnt - base, vt[v].n + PFX);
            check($sformatf("vec%0d_error", v), {31'd0, bus.error}, 32'd0);
            check($sformatf("vec%0d_busy_held", v), {31'd0, busy_gap}, 32'd0);
            check($sformatf("vec%0d_done_latency", v), done_cyc - fall_cyc, 32'd1);
            check($sformatf("vec%0d_drained", v), exp_q.size(), 32'd0);
        end

        // Out-of-range sizes are rejected without leaving IDLE
        busy_len = 2;
        base = start_cnt;
        send_cmd(1'b1, 8'd0, 1024'h55);
        @(negedge clk);
        check("size0_error", {31'd0, bus.error}, 32'd1);
        check("size0_done", {31'd0, bus.done}, 32'd1);
        send_cmd(1'b1, 8'd129, 1024'h55);
        @(negedge clk);
        check("size129_error", {31'd0, bus.error}, 32'd1);
        check("size129_done", {31'd0, bus.done}, 32'd1);
        repeat (4) @(negedge clk);
        check("reject_no_start", start_cnt - base, 32'd0);

        // Valid send clears error; tx_start two cycles after the send cycle
        if (PFX == 1) exp_q.push_back(8'h01);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h0D);
        send_cmd(1'b1, 8'd1, 1024'h33);
        @(negedge clk);
        check("accept_clears_error", {31'd0, bus.error}, 32'd0);
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
        check("latency_s1_no_start", {31'd0, bus.tx_start}, 32'd0);
        @(negedge clk);
        check("latency_s2_start", {31'd0, bus.tx_start}, 32'd1);
        check("latency_cycle", cyc - send_cyc, 32'd2);
        wait_done(2000, fall_cyc, done_cyc, busy_gap);
        check("recover_starts", start_cnt - base, 32'd2 + PFX);
        check("recover_drained", exp_q.size(), 32'd0);

        // Timeout: the UART never acknowledges the first byte
        uart_en = 1'b0;
        base = start_cnt;
        exp_q.push_back((PFX == 1) ? 8'h02 : 8'h61);
        send_cmd(1'b1, 8'd2, 1024'h6261);
        repeat (17) @(negedge clk);
        check("tmo_before_busy", {31'd0, bus.busy}, 32'd1);
        check("tmo_before_error", {31'd0, bus.error}, 32'd0);
        @(negedge clk);
        check("tmo_error", {31'd0, bus.error}, 32'd1);
        check("tmo_done", {31'd0, bus.done}, 32'd1);
        check("tmo_busy", {31'd0, bus.busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("tmo_single_start", start_cnt - base, 32'd1);
        uart_en = 1'b1;

        // Reset during byte 2 of a 5-byte command, with a stray send while busy
        busy_len = 4;
        base = start_cnt;
        if (PFX == 1) exp_q.push_back(8'h05);
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'h0D);
        send_cmd(1'b1, 8'd5, 1024'h05_0403_0201);
        for (int i = 0; i < 200 && (start_cnt - base) < 2; i++) @(negedge clk);
        check("pre_reset_starts", start_cnt - base, 32'd2);
        send_cmd(1'b0, 8'd3, 1024'hFF_FFFF);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd1);
        check("midrst_error", {31'd0, bus.error}, 32'd0);
        check("midrst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        check("midrst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        exp_q.delete();
        base = start_cnt;
        repeat (8) @(negedge clk);
        check("midrst_no_start", start_cnt - base, 32'd0);
        if (PFX == 1) exp_q.push_back(8'h05);
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'h0D);
        send_cmd(1'b1, 8'd5, 1024'h05_0403_0201);
        wait_done(2000, fall_cyc, done_cyc, busy_gap);
        check("restart_starts", start_cnt - base, 32'd6 + PFX);
        check("restart_drained", exp_q.size(), 32'd0);
        check("restart_error", {31'd0, bus.error}, 32'd0);

        // Maximum size: 128 bytes of 0xA5 then 0x0D
        busy_len = 1;
        base = start_cnt;
        if (PFX == 1) exp_q.push_back(8'h80);
        for (int b = 0; b < 128; b++) exp_q.push_back(8'hA5);
        exp_q.push_back(8'h0D);
        big = {128{8'hA5}};
        send_cmd(1'b1, 8'd128, big);
        wait_done(3000, fall_cyc, done_cyc, busy_gap);
        check("max_starts", start_cnt - base, 32'd129 + PFX);
        check("max_drained", exp_q.size(), 32'd0);
        check("max_error", {31'd0, bus.error}, 32'd0);
        check("max_busy_held", {31'd0, busy_gap}, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
